// File: rtl/soc_bus_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : soc_bus_interconnect
// Function : Single-master registered bus interconnect with N 64 KB regions.
//            Optional error capture enabled by macro BUS_ERR_CAPTURE_EN.
// Revision : 1.0
// ============================================================================
module soc_bus_interconnect #(
    parameter int                        NUM_SLAVES     = 4,
    parameter int                        DATA_W         = 32,
    // Slave 0 occupies the least-significant 16 bits.
    parameter logic [NUM_SLAVES*16-1:0]  SLAVE_BASE     = {16'h4002, 16'h2000, 16'h4001, 16'h4000},
    parameter int                        TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic                         m_we,
    input  logic                         m_re,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_ready,
    output logic                         m_error,
    output logic [15:0]                  s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [NUM_SLAVES-1:0]        s_we,
    output logic [NUM_SLAVES-1:0]        s_re,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ready,
    output logic [31:0]                  err_addr,
    output logic [7:0]                   err_count
);

    localparam int        SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic                    is_write_q, is_write_d;
    logic [15:0]             s_addr_q, s_addr_d;
    logic [DATA_W-1:0]       s_wdata_q, s_wdata_d;
    logic [NUM_SLAVES-1:0]   s_we_q, s_we_d;
    logic [NUM_SLAVES-1:0]   s_re_q, s_re_d;
    logic [DATA_W-1:0]       m_rdata_q, m_rdata_d;
    logic                    m_ready_q, m_ready_d;
    logic                    m_error_q, m_error_d;

    logic                    w_hit;
    logic [SEL_W-1:0]        w_hit_idx;
    logic [NUM_SLAVES-1:0]   w_onehot;

    // Scan downwards so the lowest matching region index wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (m_addr[31:16] == SLAVE_BASE[16*i +: 16]) begin
                w_hit     = 1'b1;
                w_hit_idx = SEL_W'(i);
            end
        end
        w_onehot = NUM_SLAVES'(1) << w_hit_idx;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        is_write_d = is_write_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        s_we_d     = s_we_q;
        s_re_d     = s_re_q;
        m_rdata_d  = '0;
        m_ready_d  = 1'b0;
        m_error_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_we | m_re) begin
                    s_addr_d   = m_addr[15:0];
                    s_wdata_d  = m_wdata;
                    is_write_d = m_we;
                    sel_d      = w_hit_idx;
                    cnt_d      = 8'd0;
                    if (w_hit) begin
                        state_d = ACCESS;
                        if (m_we) begin
                            s_we_d = w_onehot;
                        end else begin
                            s_re_d = w_onehot;
                        end
                    end else begin
                        state_d   = RESP;
                        m_ready_d = 1'b1;
                        m_error_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // Ready is checked first so it wins over a coincident timeout.
                if (s_ready[sel_q]) begin
                    state_d   = RESP;
                    m_ready_d = 1'b1;
                    s_we_d    = '0;
                    s_re_d    = '0;
                    if (!is_write_q) begin
                        m_rdata_d = s_rdata[int'(sel_q)*DATA_W +: DATA_W];
                    end
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d   = RESP;
                    m_ready_d = 1'b1;
                    m_error_d = 1'b1;
                    s_we_d    = '0;
                    s_re_d    = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                s_we_d  = '0;
                s_re_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            sel_q      <= '0;
            is_write_q <= 1'b0;
            s_addr_q   <= 16'd0;
            s_wdata_q  <= '0;
            s_we_q     <= '0;
            s_re_q     <= '0;
            m_rdata_q  <= '0;
            m_ready_q  <= 1'b0;
            m_error_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            is_write_q <= is_write_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_we_q     <= s_we_d;
            s_re_q     <= s_re_d;
            m_rdata_q  <= m_rdata_d;
            m_ready_q  <= m_ready_d;
            m_error_q  <= m_error_d;
        end
    end

    assign m_rdata = m_rdata_q;
    assign m_ready = m_ready_q;
    assign m_error = m_error_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign s_we    = s_we_q;
    assign s_re    = s_re_q;

`ifdef BUS_ERR_CAPTURE_EN
    logic [15:0] addr_hi_q, addr_hi_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic [7:0]  err_count_q, err_count_d;

    // Capture happens while the errored response is on the bus.
    always_comb begin
        addr_hi_d   = addr_hi_q;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        if ((state_q == IDLE) && (m_we | m_re)) begin
            addr_hi_d = m_addr[31:16];
        end
        if ((state_q == RESP) && m_error_q) begin
            err_addr_d = {addr_hi_q, s_addr_q};
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_hi_q   <= 16'd0;
            err_addr_q  <= 32'd0;
            err_count_q <= 8'd0;
        end else begin
            addr_hi_q   <= addr_hi_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;
`else
    assign err_addr  = 32'd0;
    assign err_count = 8'd0;
`endif

endmodule
`default_nettype wire
